vec_mem_arbiter: RTL and testbench

// Shares the single 16-bit memory port (Addr/RD/WR/dataOut/DataIn) between two burst requesters:

---
 rtl/vec_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_vec_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: shares one 16-bit memory port between two burst requesters.
// Requester 0 is the CVP14 core, requester 1 the host/DMA loader. Whole bursts
// of 1..2**LEN_W words are granted round-robin; the arbiter sequences the
// addresses, strobes and beat indices and returns read data with a per-beat valid.
//
// Ports:
//   Clk1, Reset_n          clock, asynchronous active-low reset
//   req[1:0], we[1:0]      per-requester burst request / write-not-read
//   base0/1, len0/1        start address and beats-1 of each requester
//   wdata0/1               write word of the current beat
//   gnt, beat, done        one-hot owner, beat index, final-cycle pulse
//   rvalid, rdata          read word return (rdata = DataIn)
//   Addr, RD, WR, dataOut  memory side outputs
//   DataIn                 memory read data, valid the cycle after RD
module vec_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              Clk1,
    input  logic              Reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [LEN_W-1:0]  beat,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        done,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] dataOut,
    input  logic [DATA_W-1:0] DataIn
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RTAIL,
        S_WRITE
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_base;
    logic                r_own;
    logic                r_rr;
    logic [1:0]          r_gnt;
    logic [LEN_W-1:0]    r_beat;
    logic                r_rvalid;
    logic [1:0]          r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic                r_wr;

    state_t              w_state;
    logic [LEN_W-1:0]    w_cnt;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W-1:0]   w_base;
    logic                w_own;
    logic                w_rr;
    logic [1:0]          w_gnt;
    logic [LEN_W-1:0]    w_beat;
    logic                w_rvalid;
    logic [1:0]          w_done;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_rd;
    logic                w_wr;

    logic                w_win;
    logic [1:0]          w_win_gnt;
    logic [ADDR_W-1:0]   w_sel_base;
    logic [LEN_W-1:0]    w_sel_len;
    logic                w_sel_we;
    logic                w_last;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic [ADDR_W-1:0]   w_next_addr;

    // Pointer side wins if it is requesting, otherwise the other side.
    assign w_win       = req[r_rr] ? r_rr : ~r_rr;
    assign w_win_gnt   = w_win ? 2'b10 : 2'b01;
    assign w_sel_base  = w_win ? base1 : base0;
    assign w_sel_len   = w_win ? len1 : len0;
    assign w_sel_we    = w_win ? we[1] : we[0];
    assign w_last      = (r_cnt == r_len);
    assign w_cnt_inc   = r_cnt + 1'b1;
    // Address arithmetic wraps modulo 2**ADDR_W by truncation.
    assign w_next_addr = r_base + {{(ADDR_W-LEN_W){1'b0}}, w_cnt_inc};

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_len    = r_len;
        w_base   = r_base;
        w_own    = r_own;
        w_rr     = r_rr;
        w_gnt    = r_gnt;
        w_beat   = r_beat;
        w_rvalid = 1'b0;
        w_done   = 2'b00;
        w_addr   = r_addr;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_gnt  = 2'b00;
                w_beat = '0;
                if (|req) begin
                    w_own  = w_win;
                    w_base = w_sel_base;
                    w_len  = w_sel_len;
                    w_cnt  = '0;
                    w_gnt  = w_win_gnt;
                    w_addr = w_sel_base;
                    if (w_sel_we) begin
                        w_state = S_WRITE;
                        w_wr    = 1'b1;
                        // A one-word write is also its own final cycle.
                        if (w_sel_len == '0) begin
                            w_done = w_win_gnt;
                        end
                    end else begin
                        w_state = S_READ;
                        w_rd    = 1'b1;
                    end
                end
            end
            S_READ: begin
                // The word strobed this cycle returns next cycle.
                w_rvalid = 1'b1;
                w_beat   = r_cnt;
                if (w_last) begin
                    w_state = S_RTAIL;
                    w_done  = r_gnt;
                end else begin
                    w_cnt  = w_cnt_inc;
                    w_addr = w_next_addr;
                    w_rd   = 1'b1;
                end
            end
            S_RTAIL: begin
                w_state = S_IDLE;
                w_gnt   = 2'b00;
                w_beat  = '0;
                w_rr    = ~r_own;
            end
            S_WRITE: begin
                if (w_last) begin
                    w_state = S_IDLE;
                    w_gnt   = 2'b00;
                    w_beat  = '0;
                    w_rr    = ~r_own;
                end else begin
                    w_cnt  = w_cnt_inc;
                    w_addr = w_next_addr;
                    w_wr   = 1'b1;
                    w_beat = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_done = r_gnt;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_gnt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_base   <= '0;
            r_own    <= 1'b0;
            r_rr     <= 1'b0;
            r_gnt    <= 2'b00;
            r_beat   <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 2'b00;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_len    <= w_len;
            r_base   <= w_base;
            r_own    <= w_own;
            r_rr     <= w_rr;
            r_gnt    <= w_gnt;
            r_beat   <= w_beat;
            r_rvalid <= w_rvalid;
            r_done   <= w_done;
            r_addr   <= w_addr;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
        end
    end

    assign gnt     = r_gnt;
    assign beat    = r_beat;
    assign rvalid  = r_rvalid;
    assign rdata   = DataIn;
    assign done    = r_done;
    assign Addr    = r_addr;
    assign RD      = r_rd;
    assign WR      = r_wr;
    assign dataOut = r_wr ? (r_own ? wdata1 : wdata0) : '0;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb_vec_mem_arbiter: self-checking bench for vec_mem_arbiter.
// Burst-level reference model expands each granted burst into expected bus cycles.
module tb_vec_mem_arbiter;

    logic        Clk1 = 1'b0;
    logic        Reset_n;
    logic [1:0]  req, we;
    logic [15:0] base0, base1;
    logic [3:0]  len0, len1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt;
    logic [3:0]  beat;
    logic        rvalid;
    logic [15:0] rdata;
    logic [1:0]  done;
    logic [15:0] Addr;
    logic        RD, WR;
    logic [15:0] dataOut;
    logic [15:0] DataIn;

    always #5 Clk1 = ~Clk1;

    vec_mem_arbiter dut (
        .Clk1(Clk1), .Reset_n(Reset_n), .req(req), .we(we),
        .base0(base0), .base1(base1), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .beat(beat),
        .rvalid(rvalid), .rdata(rdata), .done(done), .Addr(Addr),
        .RD(RD), .WR(WR), .dataOut(dataOut), .DataIn(DataIn)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic        rd;
        logic        wr;
        logic        rvalid;
        logic [1:0]  done;
        logic [15:0] addr;
        logic [15:0] raddr;
        logic [3:0]  beat;
        logic        own;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [15:0] mem [0:65535];
    logic [15:0] next_din;
    bit          rr;
    int          checks = 0;
    int          failures = 0;

    function automatic exp_t idle_entry();
        exp_t e;
        e.gnt = 2'b00; e.rd = 1'b0; e.wr = 1'b0; e.rvalid = 1'b0;
        e.done = 2'b00; e.addr = 16'h0; e.raddr = 16'h0;
        e.beat = 4'h0; e.own = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst-level model: winner, then L+1 read cycles or L write cycles, then one idle.
    task automatic plan_burst();
        bit          w;
        bit          isw;
        logic [15:0] b;
        int          L;
        exp_t        e;
        w   = req[rr] ? rr : ~rr;
        b   = w ? base1 : base0;
        L   = int'(w ? len1 : len0) + 1;
        isw = w ? we[1] : we[0];
        rr  = ~w;
        if (!isw) begin
            for (int k = 0; k <= L; k++) begin
                e = idle_entry();
                e.gnt = w ? 2'b10 : 2'b01;
                e.own = w;
                e.rd = (k < L);
                e.addr = 16'(int'(b) + k);
                e.rvalid = (k > 0);
                e.raddr = 16'(int'(b) + k - 1);
                e.beat = 4'(k - 1);
                e.done = (k == L) ? e.gnt : 2'b00;
                q.push_back(e);
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                e = idle_entry();
                e.gnt = w ? 2'b10 : 2'b01;
                e.own = w;
                e.wr = 1'b1;
                e.addr = 16'(int'(b) + k);
                e.beat = 4'(k);
                e.done = (k == L - 1) ? e.gnt : 2'b00;
                q.push_back(e);
            end
        end
        q.push_back(idle_entry());
    endtask

    task automatic compare();
        logic [15:0] wexp;
        chk("gnt", gnt, cur.gnt);
        chk("RD", RD, cur.rd);
        chk("WR", WR, cur.wr);
        chk("rvalid", rvalid, cur.rvalid);
        chk("done", done, cur.done);
        if (cur.rd || cur.wr) chk("Addr", Addr, cur.addr);
        if (cur.wr || cur.rvalid) chk("beat", beat, cur.beat);
        if (cur.rvalid) chk("rdata", rdata, mem[cur.raddr]);
        wexp = cur.wr ? (cur.own ? wdata1 : wdata0) : 16'h0;
        chk("dataOut", dataOut, wexp);
    endtask

    task automatic cycle();
        @(posedge Clk1);
        if (q.size() == 0 && Reset_n && req != 2'b00) plan_burst();
        if (q.size() != 0) cur = q.pop_front();
        else cur = idle_entry();
        #1;
        DataIn = next_din;
        wdata0 = 16'($urandom);
        wdata1 = 16'($urandom);
        @(negedge Clk1);
        compare();
        if (WR) mem[Addr] = dataOut;
        next_din = RD ? mem[Addr] : 16'($urandom);
    endtask

    task automatic run_until_done(input logic [1:0] mask, input int budget);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < budget) begin
            cycle();
            n++;
            if ((done & mask) != 2'b00) seen = 1'b1;
        end
        chk("burst_done_within_budget", seen, 1'b1);
        req = req & ~mask;
    endtask

    task automatic rnd_req(input int r);
        logic [15:0] b;
        b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF4 + $urandom_range(0, 11))
                                        : 16'($urandom);
        if (r == 0) begin
            base0 = b; len0 = 4'($urandom_range(0, 15));
        end else begin
            base1 = b; len1 = 4'($urandom_range(0, 15));
        end
        we[r] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int n_gnt, n_rv, ndone;
        Reset_n = 1'b0; req = 2'b00; we = 2'b00;
        base0 = 16'h0; base1 = 16'h0; len0 = 4'h0; len1 = 4'h0;
        wdata0 = 16'h0; wdata1 = 16'h0; DataIn = 16'h0; next_din = 16'h0;
        rr = 1'b0;
        cur = idle_entry();
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i ^ 16'hA5C3);

        // reset state
        repeat (2) @(negedge Clk1);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_RD", RD, 1'b0);
        chk("rst_WR", WR, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_done", done, 2'b00);
        chk("rst_beat", beat, 4'h0);
        chk("rst_Addr", Addr, 16'h0);
        chk("rst_dataOut", dataOut, 16'h0);
        Reset_n = 1'b1;
        repeat (2) cycle();

        // 16-beat read from req0
        req = 2'b01; we = 2'b00; base0 = 16'h0100; len0 = 4'hF;
        n_gnt = 0; n_rv = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (gnt == 2'b01) n_gnt++;
            if (rvalid) n_rv++;
            if (done[0]) break;
        end
        chk("t2_last_beat", beat, 4'hF);
        req = 2'b00;
        chk("t2_gnt_cycles", n_gnt, 17);
        chk("t2_rvalid_beats", n_rv, 16);
        repeat (2) cycle();

        // both requesting, read vs write, alternating
        base0 = 16'($urandom); base1 = 16'($urandom);
        len0 = 4'd3; len1 = 4'd3; we = 2'b10; req = 2'b11;
        repeat (24) cycle();
        req = 2'b00;
        repeat (12) cycle();

        // write wrapping past 0xFFFF
        req = 2'b10; we = 2'b10; base1 = 16'hFFFE; len1 = 4'd3;
        run_until_done(2'b10, 10);
        repeat (2) cycle();

        // single-word read then single-word write
        req = 2'b01; we = 2'b00; base0 = 16'h0040; len0 = 4'd0;
        run_until_done(2'b01, 6);
        cycle();
        req = 2'b01; we = 2'b01; base0 = 16'h0041;
        run_until_done(2'b01, 6);
        repeat (2) cycle();

        // req dropped mid-write does not abort
        req = 2'b01; we = 2'b01; base0 = 16'h3000; len0 = 4'd7;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (done[0]) ndone++;
            if (cur.wr && cur.beat == 4'd2) req = 2'b00;
        end
        chk("t6_done_pulses", ndone, 1);

        // async reset in the middle of a read
        req = 2'b01; we = 2'b00; base0 = 16'h2000; len0 = 4'hF;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (cur.rvalid && cur.beat == 4'd5) break;
        end
        #2 Reset_n = 1'b0;
        #1;
        chk("t1_RD_on_reset", RD, 1'b0);
        chk("t1_gnt_on_reset", gnt, 2'b00);
        chk("t1_rvalid_on_reset", rvalid, 1'b0);
        chk("t1_done_on_reset", done, 2'b00);
        q.delete();
        rr = 1'b0;
        cur = idle_entry();
        next_din = 16'h0;
        @(negedge Clk1);
        req = 2'b11; we = 2'b00; len0 = 4'd1; len1 = 4'd1;
        base0 = 16'h0500; base1 = 16'h0600;
        @(negedge Clk1);
        Reset_n = 1'b1;
        cycle();
        chk("t1_regrant_req0", gnt, 2'b01);
        run_until_done(2'b01, 8);
        run_until_done(2'b10, 8);
        repeat (2) cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (req[r] && done[r]) req[r] = 1'b0;
                else if (!req[r] && $urandom_range(0, 3) == 0) begin
                    rnd_req(r);
                    req[r] = 1'b1;
                end else if (req[r] && gnt[r] && $urandom_range(0, 7) == 0)
                    rnd_req(r);
            end
            cycle();
        end
        req = 2'b00;
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
